// File: rtl/time_alarm_bank.sv
// time_alarm_bank: 24-hour hh:mm:ss time of day plus three hh:mm alarm
// setpoints with latched ALARM flags. The time of day advances on a 1 Hz
// TICK. Manual increments come from rising-edge-detected IC/IAn strobes.
// The optional snooze countdown is built only when TAB_SNOOZE_EN is defined.
module time_alarm_bank #(
    parameter int SNOOZE_MIN = 9
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK,
    input  logic       RC,
    input  logic       IC,
    input  logic       RA1,
    input  logic       RA2,
    input  logic       RA3,
    input  logic       IA1,
    input  logic       IA2,
    input  logic       IA3,
    input  logic [2:0] EN,
    input  logic [2:0] ACK,
    input  logic       SNOOZE,
    output logic [4:0] HOURS,
    output logic [5:0] MINUTES,
    output logic [5:0] SECONDS,
    output logic [4:0] A1_HR,
    output logic [4:0] A2_HR,
    output logic [4:0] A3_HR,
    output logic [5:0] A1_MIN,
    output logic [5:0] A2_MIN,
    output logic [5:0] A3_MIN,
    output logic [2:0] ALARM
);

    // Advance hh:mm by one minute, wrapping 59->0 into hours and 23->0.
    function automatic logic [10:0] inc_min(input logic [4:0] hr, input logic [5:0] mn);
        if (mn == 6'd59)
            return {(hr == 5'd23) ? 5'd0 : hr + 5'd1, 6'd0};
        else
            return {hr, mn + 6'd1};
    endfunction

    logic       ic_q;
    logic [2:0] ia_q;
    logic       ic_edge;
    logic [2:0] ia_edge;
    logic [2:0] ia_in;
    logic [2:0] ra_in;

    logic [4:0] hr_nx;
    logic [5:0] min_nx;
    logic [5:0] sec_nx;
    logic       min_carry;

    logic [4:0] a_hr     [3];
    logic [5:0] a_min    [3];
    logic [4:0] a_hr_nx  [3];
    logic [5:0] a_min_nx [3];
    logic [2:0] alarm_nx;
    logic [2:0] snz_fire;
    logic [2:0] snz_clr;

    assign ia_in   = {IA3, IA2, IA1};
    assign ra_in   = {RA3, RA2, RA1};
    assign ic_edge = IC & ~ic_q;
    assign ia_edge = ia_in & ~ia_q;

    assign A1_HR  = a_hr[0];
    assign A2_HR  = a_hr[1];
    assign A3_HR  = a_hr[2];
    assign A1_MIN = a_min[0];
    assign A2_MIN = a_min[1];
    assign A3_MIN = a_min[2];

    // Time-of-day next state: clear beats manual increment beats TICK.
    // A match can only come from the TICK seconds carry (min_carry).
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        hr_nx     = HOURS;
        min_nx    = MINUTES;
        sec_nx    = SECONDS;
        min_carry = 1'b0;
        if (!RC) begin
            hr_nx  = '0;
            min_nx = '0;
            sec_nx = '0;
        end else if (ic_edge) begin
            {hr_nx, min_nx} = inc_min(HOURS, MINUTES);
            sec_nx          = '0;
        end else if (TICK) begin
            if (SECONDS == 6'd59) begin
                {hr_nx, min_nx} = inc_min(HOURS, MINUTES);
                sec_nx          = '0;
                min_carry       = 1'b1;
            end else begin
                sec_nx = SECONDS + 6'd1;
            end
        end
    end

`ifdef TAB_SNOOZE_EN
    logic       snz_act [3];
    logic [5:0] snz_cnt [3];

    // Snooze request clears the active flags and decides when a countdown expires.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            snz_clr[i]  = SNOOZE & ALARM[i];
            snz_fire[i] = snz_act[i] & min_carry & (snz_cnt[i] == 6'd1) & EN[i];
        end
    end

    // Per-alarm snooze countdown in minutes; cancelled by clear, ACK or disarm.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 3; i++) begin
                snz_act[i] <= 1'b0;
                snz_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!ra_in[i] || ACK[i] || !EN[i]) begin
                    snz_act[i] <= 1'b0;
                end else if (snz_clr[i]) begin
                    snz_act[i] <= 1'b1;
                    snz_cnt[i] <= 6'(SNOOZE_MIN);
                end else if (snz_act[i] && min_carry) begin
                    if (snz_cnt[i] == 6'd1)
                        snz_act[i] <= 1'b0;
                    snz_cnt[i] <= snz_cnt[i] - 6'd1;
                end
            end
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = SNOOZE ^ (SNOOZE_MIN == 0);
    assign snz_clr       = '0;
    assign snz_fire      = '0;
`endif

    // Alarm setpoint and flag next state, compared against the updated time.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            a_hr_nx[i]  = a_hr[i];
            a_min_nx[i] = a_min[i];
            alarm_nx[i] = ALARM[i];
            if (!ra_in[i]) begin
                a_hr_nx[i]  = '0;
                a_min_nx[i] = '0;
            end else if (ia_edge[i]) begin
                {a_hr_nx[i], a_min_nx[i]} = inc_min(a_hr[i], a_min[i]);
            end
            if (!ra_in[i])
                alarm_nx[i] = 1'b0;
            else if ((min_carry && EN[i] && a_hr_nx[i] == hr_nx && a_min_nx[i] == min_nx)
                     || snz_fire[i])
                alarm_nx[i] = 1'b1;
            else if (ACK[i] || !EN[i] || snz_clr[i])
                alarm_nx[i] = 1'b0;
        end
    end

    // State registers: edge-detect copies, time of day, setpoints and flags.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ic_q    <= 1'b0;
            ia_q    <= '0;
            HOURS   <= '0;
            MINUTES <= '0;
            SECONDS <= '0;
            ALARM   <= '0;
            // NOTE: these small setpoint arrays are flops with a defined reset value, not RAM, so resetting them is required.
            for (int i = 0; i < 3; i++) begin
                a_hr[i]  <= '0;
                a_min[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            ic_q    <= IC;
            ia_q    <= ia_in;
            HOURS   <= hr_nx;
            MINUTES <= min_nx;
            SECONDS <= sec_nx;
            ALARM   <= alarm_nx;
            for (int i = 0; i < 3; i++) begin
                a_hr[i]  <= a_hr_nx[i];
                a_min[i] <= a_min_nx[i];
            end
        end
    end

endmodule

// File: doc/time_alarm_bank.md
# time_alarm_bank

Counter bank at the receiving end of the selector-routed reset/increment strobes (RC/IC for the time-of-day clock, RAn/IAn for alarms 1–3). It keeps a 24-hour hh:mm:ss time of day advanced by a 1 Hz tick, plus three hh:mm alarm setpoints. Each alarm has a match latch that raises ALARM[n] until it is acknowledged. It sits between the strobe router and the display/buzzer logic.

## Interface
- SNOOZE_MIN, 9: snooze delay in minutes, 1–59. Used only with TAB_SNOOZE_EN.
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset for the whole block.
- TICK  in  1  one-cycle 1 Hz pulse that advances seconds.
- RC  in  1  active-low clear for the time of day; idles high.
- IC  in  1  time-of-day minute increment request; level-held while the button is pressed.
- RA1, RA2, RA3  in  1 each  active-low clear for alarm n; idles high.
- IA1, IA2, IA3  in  1 each  alarm n minute increment request; level-held.
- EN  in  3  EN[n-1] arms alarm n.
- ACK  in  3  ACK[n-1] clears ALARM[n-1].
- SNOOZE  in  1  one-cycle snooze request. The port is always present.
- HOURS  out  5  time-of-day hours, 0–23.
- MINUTES  out  6  time-of-day minutes, 0–59.
- SECONDS  out  6  time-of-day seconds, 0–59.
- A1_HR, A2_HR, A3_HR  out  5 each  alarm n hours.
- A1_MIN, A2_MIN, A3_MIN  out  6 each  alarm n minutes.
- ALARM  out  3  alarm n active flags.

## Operation
- Reset state (RESET low): all outputs 0; internal edge registers 0; snooze counters idle.
- Increment strobes are rising-edge detected against a registered copy.
  - One increment per 0→1 transition of IC or IAn.
  - Holding the line high has no further effect.
- Time-of-day priority per cycle, highest first:
  1. RC low: hh:mm:ss ← 00:00:00. The IC edge and TICK are ignored.
  2. IC edge: minutes +1 and seconds ← 0. TICK is ignored that cycle.
     - Minutes wrap 59→0 with hours +1.
     - Hours wrap 23→0.
  3. TICK: seconds +1, carrying 59→0 into minutes and then hours with the same wrap rules.
- Alarm n setpoints, priority per cycle:
  1. RAn low: setpoint ← 00:00 and ALARM[n-1] ← 0.
  2. IAn edge: setpoint minutes +1 with the same minute/hour wrap rules.
- Match event:
  - Occurs only when a TICK carry moves the time to hh:mm:00 (seconds 59→0).
  - Manual setting through RC or IC never generates a match.
  - On a match with alarm n at hh:mm and EN[n-1]=1, ALARM[n-1] is set on the same edge.
- Clearing ALARM[n-1]:
  - ACK[n-1]=1, EN[n-1]=0, or RAn low.
  - If a set and an ACK occur in the same cycle, the set wins.
- Setpoints are compared as they stand after the current edge's updates. An alarm edited to equal the new time in the same cycle still matches.

## Timing
- Every output is a register, updated on the CLK edge at which the causing input is sampled. Visible latency is 1 cycle.
- An IC/IAn rising edge sampled at edge k changes MINUTES/Ax_MIN after edge k. A held level produces nothing at k+1.
- A TICK on the cycle that makes 23:59:59 produce 00:00:00 wraps all three fields on one edge.
- RESET assertion clears immediately, with no clock needed. Deassertion is synchronized externally.
- Reset mid-increment: the edge registers clear to 0. A line still high at release counts as a new rising edge on the first clock after release.
- Simultaneous IC edge and IAn edge are processed independently in the same cycle.

## Configuration
- TAB_SNOOZE_EN defined:
  - A SNOOZE pulse while any ALARM bit is set clears those bits.
  - For each cleared alarm it loads a per-alarm countdown of SNOOZE_MIN minutes, decremented on each TICK minute carry.
  - At 0 the countdown re-sets ALARM[n-1] if EN[n-1] is still 1.
  - RAn low, ACK[n-1], or EN[n-1]=0 cancel that alarm's countdown.
- TAB_SNOOZE_EN undefined: the SNOOZE input is ignored and no countdown logic is built.

## Test plan
- Reset then 3661 TICKs → 01:01:01. Continue to 23:59:59, then one TICK → 00:00:00 with all three fields changing on a single edge.
- IC held high 10 cycles from 05:30:42 → 05:31:00 after the first edge, then unchanged. IC low then high again → 05:32:00.
- IA2 raised 3 times (edges separated) from reset → A2 = 00:03. RA2 low for one cycle → A2 = 00:00.
- A1 = 06:00, EN=3'b001, time 05:59:59, TICK → ALARM=3'b001 on that edge.
  - Same setup with EN=0 → ALARM stays 0.
  - Setting the time to 06:00 via IC → no alarm.
- ALARM[0] set, ACK=3'b001 on the same edge as a new match → ALARM[0] stays 1. ACK on a later cycle → 0.
- With TAB_SNOOZE_EN and SNOOZE_MIN=2: alarm at 07:00:00, SNOOZE at 07:00:10 → ALARM 0, re-set at 07:02:00. Without the macro → SNOOZE has no effect.
